// File: rtl/gsr_pur_assign.sv
// Chip-wide active-low PUR/GSR reset generator for IO/DDR primitive models.
// Both nets assert asynchronously with RSTN and release synchronously to SCLK, PUR before GSR.
module gsr_pur_assign #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PUR_CYCLES  = 16,
    parameter int unsigned GSR_CYCLES  = 4,
    parameter int unsigned GSR_ENABLED = 1
) (
    output logic GSR,
    output logic PUR,
    input  logic SCLK,
    input  logic RSTN,
    input  logic GSR_REQN
);

    localparam int unsigned PW = $clog2(PUR_CYCLES + 1);
    localparam int unsigned GW = $clog2(GSR_CYCLES + 1);
    localparam logic [PW-1:0] PUR_MAX = PW'(PUR_CYCLES);
    localparam logic [GW-1:0] GSR_MAX = GW'(GSR_CYCLES);

    logic [SYNC_STAGES-1:0] rst_chain;
    logic [SYNC_STAGES-1:0] req_chain;
    logic                   rst_sync;
    logic                   req_sync;
    logic [PW-1:0]          p_cnt;
    logic [PW-1:0]          p_cnt_nxt_c;
    logic [GW-1:0]          g_cnt;
    logic                   gsr_clear_c;

    // Reset release synchronizer: ones shift in once RSTN is high.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            rst_chain <= '0;
        end else begin
            rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Request synchronizer idles at 1 (no request) through reset.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            req_chain <= '1;
        end else begin
            req_chain <= {req_chain[SYNC_STAGES-2:0], GSR_REQN};
        end
    end

    assign rst_sync = rst_chain[SYNC_STAGES-1];
    assign req_sync = req_chain[SYNC_STAGES-1];

    always_comb begin
        p_cnt_nxt_c = p_cnt;
        if (!rst_sync) begin
            p_cnt_nxt_c = '0;
        end else if (p_cnt != PUR_MAX) begin
            p_cnt_nxt_c = p_cnt + PW'(1);
        end
    end

    // PUR releases on the same edge the stretch counter saturates.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            p_cnt <= '0;
            PUR   <= 1'b0;
        end else begin
            p_cnt <= p_cnt_nxt_c;
            PUR   <= rst_sync && (p_cnt_nxt_c == PUR_MAX);
        end
    end

    assign gsr_clear_c = !PUR || ((GSR_ENABLED != 0) && !req_sync);

    // A live clear condition drops GSR on the next edge even from a saturated count.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            g_cnt <= '0;
            GSR   <= 1'b0;
        end else begin
            GSR <= !gsr_clear_c && (g_cnt == GSR_MAX);
            if (gsr_clear_c) begin
                g_cnt <= '0;
            end else if (g_cnt != GSR_MAX) begin
                g_cnt <= g_cnt + GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gsr_pur_assign.sv
// Bench for gsr_pur_assign: directed scenarios plus random traffic against a window-based model.
module tb_gsr_pur_assign;

    localparam int unsigned S = 2;
    localparam int unsigned P = 16;
    localparam int unsigned G = 4;

    logic sclk = 1'b0;
    logic rstn;
    logic gsr_reqn;
    logic gsr_e, pur_e, gsr_d, pur_d;

    always #5 sclk = ~sclk;

    gsr_pur_assign #(.SYNC_STAGES(S), .PUR_CYCLES(P), .GSR_CYCLES(G), .GSR_ENABLED(1)) dut_en (
        .GSR(gsr_e), .PUR(pur_e), .SCLK(sclk), .RSTN(rstn), .GSR_REQN(gsr_reqn));

    gsr_pur_assign #(.SYNC_STAGES(S), .PUR_CYCLES(P), .GSR_CYCLES(G), .GSR_ENABLED(0)) dut_dis (
        .GSR(gsr_d), .PUR(pur_d), .SCLK(sclk), .RSTN(rstn), .GSR_REQN(gsr_reqn));

    int tests = 0;
    int fails = 0;

    // Model: PUR is 1 once RSTN has been high for S+P edges; GSR is 1 once
    // "PUR high and no synchronized request" has held before G+1 consecutive edges.
    int rel;
    bit hist[S];
    int ok_run, ok_run_d;
    bit pur_m, gsr_m, gsr_md;

    function automatic void model_reset();
        rel = 0;
        for (int i = 0; i < S; i++) hist[i] = 1'b1;
        ok_run = 0;
        ok_run_d = 0;
        pur_m = 1'b0;
        gsr_m = 1'b0;
        gsr_md = 1'b0;
    endfunction

    function automatic void model_edge();
        bit req_seen;
        if (!rstn) begin
            model_reset();
            return;
        end
        req_seen = hist[S-1];
        ok_run   = (pur_m && req_seen) ? ok_run + 1 : 0;
        ok_run_d = pur_m ? ok_run_d + 1 : 0;
        gsr_m    = (ok_run >= G + 1);
        gsr_md   = (ok_run_d >= G + 1);
        for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = gsr_reqn;
        rel++;
        pur_m = (rel >= S + P);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pur_en"}, pur_e, pur_m);
        check({tag, "_gsr_en"}, gsr_e, gsr_m);
        check({tag, "_pur_dis"}, pur_d, pur_m);
        check({tag, "_gsr_dis"}, gsr_d, gsr_md);
    endtask

    // One rising edge, then compare everything at the falling edge.
    task automatic step();
        @(posedge sclk);
        model_edge();
        @(negedge sclk);
        check_all("cyc");
    endtask

    // Assert reset between edges and confirm both nets drop without a clock.
    task automatic assert_reset();
        rstn = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
    endtask

    // Bounded wait: edges until the chosen enabled-instance output equals val, -1 on timeout.
    task automatic wait_for(input bit use_pur, input logic val, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if ((use_pur ? pur_e : gsr_e) === val) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        int n, m;
        rstn = 1'b0;
        gsr_reqn = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        repeat (5) step();

        // Power-up release timing.
        rstn = 1'b1;
        wait_for(1'b1, 1'b1, 40, n);
        check_int("pur_rise_edge", n, S + P);
        wait_for(1'b0, 1'b1, 20, m);
        check_int("gsr_rise_edge", n + m, S + P + G + 1);

        // Mid-run request held for 10 cycles.
        repeat (5) step();
        gsr_reqn = 1'b0;
        wait_for(1'b0, 1'b0, 10, n);
        check_int("req_gsr_fall", n, S + 1);
        if (n > 0 && n < 10) repeat (10 - n) step();
        gsr_reqn = 1'b1;
        wait_for(1'b0, 1'b1, 20, n);
        check_int("req_gsr_rise", n, S + G + 1);
        check("req_pur_held", pur_e, 1'b1);
        check("dis_gsr_held", gsr_d, 1'b1);

        // Reset in the middle of the GSR stretch, then full sequence again.
        assert_reset();
        repeat (3) step();
        rstn = 1'b1;
        repeat (20) step();
        assert_reset();
        repeat (2) step();
        rstn = 1'b1;
        wait_for(1'b1, 1'b1, 40, n);
        check_int("pur_rise_again", n, S + P);
        wait_for(1'b0, 1'b1, 20, m);
        check_int("gsr_rise_again", n + m, S + P + G + 1);

        // One-cycle request pulse.
        repeat (3) step();
        gsr_reqn = 1'b0;
        step();
        gsr_reqn = 1'b1;
        repeat (S + G + 1) step();
        check("short_req_gsr", gsr_e, 1'b1);
        check("short_req_pur", pur_e, 1'b1);

        // Request held low across the PUR release.
        assert_reset();
        gsr_reqn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        repeat (25) step();
        check("overlap_pur", pur_e, 1'b1);
        check("overlap_gsr", gsr_e, 1'b0);
        gsr_reqn = 1'b1;
        wait_for(1'b0, 1'b1, 30, n);
        check_int("overlap_gsr_rise", n, S + G + 1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                assert_reset();
                repeat ($urandom_range(1, 3)) step();
                rstn = 1'b1;
            end
            if ($urandom_range(0, 11) == 0) gsr_reqn = ~gsr_reqn;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
